// File: rtl/pe_traffic_node.sv
// pe_traffic_node: synthesizable PE endpoint for one HNoC port.
// Injects NUM_PKTS single-flit packets and checks flits delivered to it.
//
// Parameters:
//   address  - this PE's 2-bit NoC address
//   NUM_PKTS - packets to inject before done (1..4095)
//   GAP      - idle cycles between an accept and the next valid (0..255)
//   SEED     - generator LFSR seed, XORed with address (0 -> 16'hACE1)
// Ports:
//   clk, rst          - clock, synchronous active-low reset
//   i_data/_valid     - flit from NoC, o_data_ready - node can accept
//   o_data/_valid     - flit to NoC,   i_data_ready - NoC accepts
//   o_sent_count      - packets accepted by the NoC (saturating)
//   o_recv_count      - flits received (saturating)
//   o_err_count       - checker errors (saturating)
//   o_done            - all NUM_PKTS accepted, sticky until reset
// Build option:
//   PE_BACKPRESSURE_EN - pseudo-random receive stalls (~25%) from an
//                        8-bit LFSR; without it o_data_ready is 1
//                        from the first cycle after reset release.

module pe_traffic_node #(
  parameter logic [1:0]  address  = 2'd0,
  parameter int          NUM_PKTS = 16,
  parameter int          GAP      = 2,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_data,
  input  logic        i_data_valid,
  output logic        o_data_ready,
  output logic [31:0] o_data,
  output logic        o_data_valid,
  input  logic        i_data_ready,
  output logic [15:0] o_sent_count,
  output logic [15:0] o_recv_count,
  output logic [15:0] o_err_count,
  output logic        o_done
);

  localparam logic [15:0] SEED_MIX =
    SEED ^ {14'd0, address};
  localparam logic [15:0] SEED_X =
    (SEED_MIX == 16'd0) ? 16'hACE1 : SEED_MIX;
  localparam logic [7:0]  GAP_W  = 8'(GAP);
  localparam logic [15:0] NUM_W  = 16'(NUM_PKTS);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } st_t;

  // ---------------- send side ----------------
  st_t         st_q;
  st_t         st_d;
  logic [7:0]  gap_q;
  logic [7:0]  gap_d;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_nx;
  logic [11:0] seq_q;
  logic [15:0] sent_q;
  logic [1:0]  tx_dst;
  logic [31:0] tx_flit;
  logic        tx_acc;
  logic        tx_last;

  assign lfsr_nx = {lfsr_q[14:0],
                    lfsr_q[15] ^ lfsr_q[13] ^
                    lfsr_q[12] ^ lfsr_q[10]};

  // never address ourselves: bump to the next PE
  assign tx_dst = (lfsr_q[1:0] == address) ?
                  address + 2'd1 : lfsr_q[1:0];

  assign tx_flit = {tx_dst, address, seq_q, lfsr_q};
  assign tx_acc  = (st_q == S_SEND) & i_data_ready;
  assign tx_last = (sent_q + 16'd1) == NUM_W;

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q  <= S_WAIT;
      gap_q <= GAP_W;
    end else begin
      st_q  <= st_d;
      gap_q <= gap_d;
    end
  end

  // after reset WAIT runs GAP+1 cycles; after an accept
  // it is entered with GAP-1 so exactly GAP idle cycles pass
  always_comb begin
    st_d  = st_q;
    gap_d = gap_q;
    unique case (st_q)
      S_WAIT: begin
        if (gap_q == 8'd0) begin
          st_d = S_SEND;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      S_SEND: begin
        if (tx_acc) begin
          if (tx_last) begin
            st_d = S_DONE;
          end else if (GAP_W == 8'd0) begin
            st_d = S_SEND;
          end else begin
            st_d  = S_WAIT;
            gap_d = GAP_W - 8'd1;
          end
        end
      end
      S_DONE: begin
        st_d = S_DONE;
      end
      default: begin
        st_d  = S_WAIT;
        gap_d = GAP_W;
      end
    endcase
  end

  // flit fields only move on accept, so o_data holds while stalled
  always_comb begin
    o_data_valid = 1'b0;
    o_done       = 1'b0;
    o_data       = 32'd0;
    unique case (st_q)
      S_SEND: begin
        o_data_valid = 1'b1;
        o_data       = tx_flit;
      end
      S_DONE: begin
        o_done = 1'b1;
      end
      default: begin
        o_data_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_q <= SEED_X;
      seq_q  <= 12'd0;
      sent_q <= 16'd0;
    end else if (tx_acc) begin
      lfsr_q <= lfsr_nx;
      seq_q  <= seq_q + 12'd1;
      if (sent_q != CNT_MAX) begin
        sent_q <= sent_q + 16'd1;
      end
    end
  end

  assign o_sent_count = sent_q;

  // ---------------- receive side ----------------
  logic        rdy_q;
  logic        rx_acc;
  logic [1:0]  rx_dst;
  logic [1:0]  rx_src;
  logic [11:0] rx_seq;
  logic        rx_bad;
  logic [11:0] exp_q [4];
  logic [15:0] recv_q;
  logic [15:0] err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
    end
  end

`ifdef PE_BACKPRESSURE_EN
  logic [7:0] rxl_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rxl_q <= 8'h5A ^ {6'd0, address};
    end else begin
      rxl_q <= {rxl_q[6:0],
                rxl_q[7] ^ rxl_q[5] ^
                rxl_q[4] ^ rxl_q[3]};
    end
  end

  assign o_data_ready = rdy_q & ~(rxl_q[1] & rxl_q[0]);
`else
  assign o_data_ready = rdy_q;
`endif

  assign rx_acc = i_data_valid & o_data_ready;
  assign rx_dst = i_data[31:30];
  assign rx_src = i_data[29:28];
  assign rx_seq = i_data[27:16];

  // any combination of faults counts once per flit
  assign rx_bad = (rx_dst != address) |
                  (rx_src == address) |
                  (rx_seq != exp_q[rx_src]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      recv_q <= 16'd0;
      err_q  <= 16'd0;
      for (int i = 0; i < 4; i++) begin
        exp_q[i] <= 12'd0;
      end
    end else if (rx_acc) begin
      if (recv_q != CNT_MAX) begin
        recv_q <= recv_q + 16'd1;
      end
      if (rx_bad && (err_q != CNT_MAX)) begin
        err_q <= err_q + 16'd1;
      end
      // resync to whatever arrived
      exp_q[rx_src] <= rx_seq + 12'd1;
    end
  end

  assign o_recv_count = recv_q;
  assign o_err_count  = err_q;

endmodule
